// File: rtl/text_console_writer.sv
// text_console_writer
//   Terminal-style character writer feeding the character/video memory.
//   Bytes arrive over a valid/ready handshake. Printable codes (0x20-0x7E)
//   are written at the cursor. CR, LF, BS and FF are interpreted as control
//   codes, and every other code is dropped. Line wrap past the last cell
//   and LF on the last row blank row 0. FF blanks the whole screen.
//
//   Optional build macro: CURSOR_BLINK_EN. When it is defined, cursor_on
//   blinks every BLINK_FRAMES frame_tick pulses. When it is undefined,
//   cursor_on is tied to 1.
//
//   Ports:
//     clk         system / pixel clock
//     clr         synchronous active-high reset
//     char_in     incoming character code
//     char_valid  char_in valid
//     char_ready  byte can be accepted this cycle (combinational)
//     frame_tick  one-cycle pulse per video frame
//     wr_en       character memory write strobe (registered)
//     wr_addr     write address, row*COLS + col (registered, holds when idle)
//     wr_data     character code to write (registered, holds when idle)
//     cursor_col  cursor column, 0..COLS-1
//     cursor_row  cursor row, 0..ROWS-1
//     cursor_on   cursor visible this frame
module text_console_writer #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int ADDR_W       = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic              frame_tick,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              cursor_on
);

  localparam int CELLS = COLS * ROWS;
  // The clear pointer has one extra bit so that it can step one past the
  // last cell even when COLS*ROWS == 2**ADDR_W.
  localparam int PW = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, CLEAR_LINE, CLEAR_ALL} state_e;

  state_e            state_q;
  logic [6:0]        col_q;
  logic [4:0]        row_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [PW-1:0]     clr_ptr_q;   // next address to blank
  logic [PW-1:0]     clr_last_q;  // last address to blank
  logic [PW-1:0]     clr_rem_q;   // cycles left in the clear state

  logic              accept;
  logic              last_col;
  logic              last_row;
  logic [ADDR_W-1:0] cur_addr;

  assign char_ready = (state_q == IDLE) && !clr;
  assign accept     = char_valid && char_ready;
  assign last_col   = (col_q == 7'(COLS - 1));
  assign last_row   = (row_q == 5'(ROWS - 1));
  assign cur_addr   = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

  // A clear state always lasts exactly its length in cycles; char_ready is
  // low for that long. LF and FF issue the first blank write on the accept
  // edge, so their clears start at pointer 1. A wrapping printable uses the
  // accept edge for its own write, so its clear starts at pointer 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      clr_ptr_q  <= '0;
      clr_last_q <= '0;
      clr_rem_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (char_in >= 8'h20 && char_in <= 8'h7E) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cur_addr;
              wr_data_q <= char_in;
              if (last_col) begin
                col_q <= '0;
                if (last_row) begin
                  row_q      <= '0;
                  state_q    <= CLEAR_LINE;
                  clr_ptr_q  <= '0;
                  clr_last_q <= PW'(COLS - 1);
                  clr_rem_q  <= PW'(COLS);
                end else begin
                  row_q <= row_q + 5'd1;
                end
              end else begin
                col_q <= col_q + 7'd1;
              end
            end else begin
              case (char_in)
                8'h0D: col_q <= '0;
                8'h0A: begin
                  if (last_row) begin
                    row_q      <= '0;
                    wr_en_q    <= 1'b1;
                    wr_addr_q  <= '0;
                    wr_data_q  <= 8'h20;
                    state_q    <= CLEAR_LINE;
                    clr_ptr_q  <= PW'(1);
                    clr_last_q <= PW'(COLS - 1);
                    clr_rem_q  <= PW'(COLS);
                  end else begin
                    row_q <= row_q + 5'd1;
                  end
                end
                8'h08: begin
                  if (col_q != 7'd0) begin
                    col_q     <= col_q - 7'd1;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= cur_addr - ADDR_W'(1);
                    wr_data_q <= 8'h20;
                  end
                end
                8'h0C: begin
                  col_q      <= '0;
                  row_q      <= '0;
                  wr_en_q    <= 1'b1;
                  wr_addr_q  <= '0;
                  wr_data_q  <= 8'h20;
                  state_q    <= CLEAR_ALL;
                  clr_ptr_q  <= PW'(1);
                  clr_last_q <= PW'(CELLS - 1);
                  clr_rem_q  <= PW'(CELLS);
                end
                default: ;
              endcase
            end
          end
        end
        CLEAR_LINE, CLEAR_ALL: begin
          if (clr_ptr_q <= clr_last_q) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= clr_ptr_q[ADDR_W-1:0];
            wr_data_q <= 8'h20;
            clr_ptr_q <= clr_ptr_q + PW'(1);
          end
          clr_rem_q <= clr_rem_q - PW'(1);
          if (clr_rem_q == PW'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt_q;
  logic          cursor_on_q;

  // Typing keeps the cursor solid; the blink phase restarts afterwards.
  always_ff @(posedge clk) begin
    if (clr) begin
      blink_cnt_q <= '0;
      cursor_on_q <= 1'b1;
    end else if (accept) begin
      blink_cnt_q <= '0;
      cursor_on_q <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        cursor_on_q <= ~cursor_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  assign cursor_on = cursor_on_q;
`else
  // frame_tick and BLINK_FRAMES have no function in this build.
  logic unused_blink;
  assign unused_blink = frame_tick | (BLINK_FRAMES < 0);
  assign cursor_on    = 1'b1;
`endif

endmodule
